// File: rtl/regfile_mp_scoreboard_pkg.sv
// Shared defaults and types for the multi-port register file with busy scoreboard.
package regfile_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;

    // Address width for a register file of nreg entries (at least one bit).
    function automatic int addr_w(input int nreg);
        return (nreg > 1) ? $clog2(nreg) : 1;
    endfunction

    localparam int AW_DEF = addr_w(NREG_DEF);

    typedef logic [AW_DEF-1:0]   reg_addr_t;
    typedef logic [XLEN_DEF-1:0] reg_data_t;

    localparam reg_data_t ZERO_WORD = '0;

endpackage

// File: rtl/regfile_mp_scoreboard_if.sv
// Read/write/issue bundle between the ID/WB stages (master) and the register file (slave).
interface regfile_mp_scoreboard_if
    import regfile_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NREG = NREG_DEF,
    parameter int NRD  = 2,
    parameter int NWR  = 1
);
    localparam int AW = addr_w(NREG);

    logic [NRD-1:0][AW-1:0]   rd_addr;
    logic [NRD-1:0][XLEN-1:0] rd_data;
    logic [NRD-1:0]           rd_busy;
    logic [NWR-1:0]           wr_en;
    logic [NWR-1:0][AW-1:0]   wr_addr;
    logic [NWR-1:0][XLEN-1:0] wr_data;
    logic                     issue_en;
    logic [AW-1:0]            issue_addr;
    logic                     issue_ok;
    logic                     flush;
    logic [AW:0]              busy_cnt;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, issue_en, issue_addr, flush,
        input  rd_data, rd_busy, issue_ok, busy_cnt
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, issue_en, issue_addr, flush,
        output rd_data, rd_busy, issue_ok, busy_cnt
    );

endinterface

// File: rtl/regfile_mp_scoreboard_busy_sb.sv
// Per-register busy scoreboard: set on issue, cleared on writeback, wiped on flush,
// with an incrementally maintained busy count.
module regfile_busy_sb
    import regfile_pkg::*;
#(
    parameter int NREG     = NREG_DEF,
    parameter int AW       = addr_w(NREG_DEF),
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREG-1:0] hit,
    input  logic            issue_en,
    input  logic [AW-1:0]   issue_addr,
    input  logic            flush,
    output logic            issue_ok,
    output logic [NREG-1:0] busy,
    output logic [AW:0]     busy_cnt
);

    localparam logic [AW:0] CNT_ONE = (AW+1)'(1);

    logic [NREG-1:0] set_vec;
    logic [NREG-1:0] busy_nxt;
    logic [AW:0]     n_set;
    logic [AW:0]     n_clr;
    logic [AW:0]     cnt_nxt;

    // Accept a reservation when the target is free or is being written back right now.
    always_comb begin
        issue_ok = 1'b0;
        if (int'(issue_addr) < NREG) begin
            if (ZERO_REG != 0 && issue_addr == '0) begin
                issue_ok = issue_en && !flush;
            end else begin
                issue_ok = issue_en && !flush &&
                           (!busy[issue_addr] || (BYPASS != 0 && hit[issue_addr]));
            end
        end
    end

    // One-hot set vector for the accepted reservation; x0 is never marked busy.
    always_comb begin
        set_vec = '0;
        if (issue_ok && !(ZERO_REG != 0 && issue_addr == '0)) begin
            set_vec[issue_addr] = 1'b1;
        end
    end

    // Busy next state (flush > issue-set > write-clear > hold) and count deltas.
    always_comb begin
        busy_nxt = busy;
        n_set    = '0;
        n_clr    = '0;
        for (int r = 0; r < NREG; r++) begin
            if (flush) begin
                busy_nxt[r] = 1'b0;
            end else if (set_vec[r]) begin
                busy_nxt[r] = 1'b1;
            end else if (hit[r]) begin
                busy_nxt[r] = 1'b0;
            end
            if (!busy[r] && busy_nxt[r]) begin
                n_set = n_set + CNT_ONE;
            end
            if (busy[r] && !busy_nxt[r]) begin
                n_clr = n_clr + CNT_ONE;
            end
        end
        cnt_nxt = flush ? '0 : (busy_cnt + n_set - n_clr);
    end

    // Busy vector and count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_nxt;
            busy_cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/regfile_mp_scoreboard.sv
// Multi-port integer register file: NRD async reads, NWR prioritised sync writes,
// optional write->read bypass, hardwired-zero x0 and an integrated busy scoreboard.
module regfile_mp_scoreboard
    import regfile_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NREG     = NREG_DEF,
    parameter int NRD      = 2,
    parameter int NWR      = 1,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    regfile_mp_scoreboard_if.slave bus
);

    localparam int AW = addr_w(NREG);

    logic [XLEN-1:0]            regs [NREG];
    logic [NREG-1:0]            wr_hit;
    logic [NREG-1:0][XLEN-1:0]  wr_sel;
    logic [NREG-1:0]            busy;

    // True for an address that maps to real, writable storage.
    function automatic logic addr_live(input logic [AW-1:0] a);
        return (int'(a) < NREG) && !(ZERO_REG != 0 && a == '0);
    endfunction

    // Write decode: ascending port scan so the highest-index port wins per register.
    always_comb begin
        wr_hit = '0;
        wr_sel = '0;
        for (int p = 0; p < NWR; p++) begin
            if (bus.wr_en[p] && addr_live(bus.wr_addr[p])) begin
                wr_hit[bus.wr_addr[p]] = 1'b1;
                wr_sel[bus.wr_addr[p]] = bus.wr_data[p];
            end
        end
    end

    // Register storage; x0 and out-of-range addresses never reach wr_hit.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                regs[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NREG; r++) begin
                if (wr_hit[r]) begin
                    regs[r] <= wr_sel[r];
                end
            end
        end
    end

    // Read ports with optional same-cycle forwarding; a forwarded write also hides busy.
    always_comb begin
        bus.rd_data = '0;
        bus.rd_busy = '0;
        for (int i = 0; i < NRD; i++) begin
            if (addr_live(bus.rd_addr[i])) begin
                if (BYPASS != 0 && wr_hit[bus.rd_addr[i]]) begin
                    bus.rd_data[i] = wr_sel[bus.rd_addr[i]];
                end else begin
                    bus.rd_data[i] = regs[bus.rd_addr[i]];
                end
                bus.rd_busy[i] = busy[bus.rd_addr[i]] &&
                                 !(BYPASS != 0 && wr_hit[bus.rd_addr[i]]);
            end
        end
    end

    regfile_busy_sb #(
        .NREG     (NREG),
        .AW       (AW),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS)
    ) u_busy_sb (
        .clk        (clk),
        .rst        (rst),
        .hit        (wr_hit),
        .issue_en   (bus.issue_en),
        .issue_addr (bus.issue_addr),
        .flush      (bus.flush),
        .issue_ok   (bus.issue_ok),
        .busy       (busy),
        .busy_cnt   (bus.busy_cnt)
    );

endmodule
